// File: rtl/command_queue.sv
// command_queue: elastic FIFO of 48-bit commands from i2c_slave, dispatched one at a time to tpu
module command_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_button,
  input  logic                  in_execute,
  input  logic [47:0]           in_command,
  output logic                  in_busy,
  output logic                  out_execute,
  output logic [47:0]           out_command,
  input  logic                  tpu_busy,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  input  logic                  clear_overflow
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [ADDR_WIDTH:0]   FULL  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   L_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] P_ONE = ADDR_WIDTH'(1);
  logic [47:0]           mem [DEPTH];
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  in_busy_q, in_busy_d;
  logic                  out_execute_q, out_execute_d;
  logic [47:0]           out_command_q, out_command_d;
  logic                  overflow_q, overflow_d;
  logic                  wr_acc, drop, dispatch;
  // Accept/drop decisions use the pre-edge level so a full FIFO drops even while dispatching
  always_comb begin
    wr_acc        = in_execute && (level_q != FULL);
    drop          = in_execute && (level_q == FULL);
    dispatch      = (state_q == IDLE) && (level_q != '0) && !tpu_busy;
    wr_ptr_d      = wr_acc ? wr_ptr_q + P_ONE : wr_ptr_q;
    rd_ptr_d      = dispatch ? rd_ptr_q + P_ONE : rd_ptr_q;
    level_d       = (wr_acc && !dispatch) ? level_q + L_ONE :
                    (!wr_acc && dispatch) ? level_q - L_ONE : level_q;
    in_busy_d     = (level_d == FULL);
    overflow_d    = drop ? 1'b1 : clear_overflow ? 1'b0 : overflow_q;
    out_execute_d = dispatch;
    out_command_d = dispatch ? mem[rd_ptr_q] : out_command_q;
    state_d       = state_q;
    case (state_q)
      IDLE:    state_d = dispatch ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = tpu_busy ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Storage is written on accepted commands only and is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= in_command;
  end
  // Control and output registers, cleared asynchronously by the reset button
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_busy_q     <= 1'b0;
      out_execute_q <= 1'b0;
      out_command_q <= 48'h0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_busy_q     <= in_busy_d;
      out_execute_q <= out_execute_d;
      out_command_q <= out_command_d;
      overflow_q    <= overflow_d;
    end
  end
  assign in_busy     = in_busy_q;
  assign out_execute = out_execute_q;
  assign out_command = out_command_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_command_queue.sv
// tb_command_queue: table vectors plus directed sequences with a dispatch-order scoreboard
module tb_command_queue;
  logic        clk = 1'b0;
  logic        reset_button;
  logic        in_execute;
  logic [47:0] in_command;
  logic        in_busy;
  logic        out_execute;
  logic [47:0] out_command;
  logic        tpu_busy;
  logic [3:0]  level;
  logic        overflow;
  logic        clear_overflow;

  command_queue #(.DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset_button(reset_button), .in_execute(in_execute), .in_command(in_command),
    .in_busy(in_busy), .out_execute(out_execute), .out_command(out_command), .tpu_busy(tpu_busy),
    .level(level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [47:0] exp_q[$];

  typedef struct {
    logic        exe;
    logic [47:0] cmd;
    logic        clr;
    logic        acc;
    logic [3:0]  lvl;
    logic        bsy;
    logic        ovf;
  } vec_t;
  vec_t tbl[13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] cmd, input logic acc);
    in_execute = 1'b1;
    in_command = cmd;
    if (acc) exp_q.push_back(cmd);
    step();
    in_execute = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    chk(name, 48'(exp_q.size()), 48'h0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expected command, last one cycle, and be >= 3 cycles apart
  logic prev_exec = 1'b0;
  int   last_pulse = -100;
  always @(negedge clk) begin
    if (!reset_button) begin
      prev_exec  = 1'b0;
      last_pulse = -100;
    end else begin
      if (out_execute) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 48'h1, 48'h0);
        else chk("dispatch_order", out_command, exp_q.pop_front());
        chk("pulse_spacing_ok", 48'(cyc - last_pulse >= 3), 48'h1);
        chk("pulse_one_cycle", 48'(prev_exec), 48'h0);
        last_pulse = cyc;
      end
      prev_exec = out_execute;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int last;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 48'hC0DE_0000_0000 | 48'(i), 1'b0, 1'b1, 4'(i + 1), i == 7, 1'b0};
    tbl[8]  = '{1'b1, 48'hDEAD_BEEF_0008, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 48'h0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 48'hDEAD_BEEF_000A, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 48'h0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 48'h0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0};

    reset_button = 1'b0; in_execute = 1'b0; in_command = '0; tpu_busy = 1'b0; clear_overflow = 1'b0;
    repeat (3) step();
    chk("rst_level", 48'(level), 48'h0);
    chk("rst_in_busy", 48'(in_busy), 48'h0);
    chk("rst_out_execute", 48'(out_execute), 48'h0);
    chk("rst_out_command", out_command, 48'h0);
    chk("rst_overflow", 48'(overflow), 48'h0);
    reset_button = 1'b1;
    repeat (2) step();

    // single command, earliest dispatch two edges after in_execute
    push(48'h0102_0304_0506, 1'b1);
    chk("t1_level_after_write", 48'(level), 48'h1);
    chk("t1_no_bypass", 48'(out_execute), 48'h0);
    step();
    chk("t1_pulse", 48'(out_execute), 48'h1);
    chk("t1_command", out_command, 48'h0102_0304_0506);
    chk("t1_level_after_dispatch", 48'(level), 48'h0);
    step();
    chk("t1_pulse_end", 48'(out_execute), 48'h0);
    chk("t1_command_held", out_command, 48'h0102_0304_0506);
    repeat (4) step();

    // fill, overflow and clear_overflow priority while tpu is busy
    tpu_busy = 1'b1;
    step();
    foreach (tbl[i]) begin
      in_execute = tbl[i].exe;
      in_command = tbl[i].cmd;
      clear_overflow = tbl[i].clr;
      if (tbl[i].acc) exp_q.push_back(tbl[i].cmd);
      step();
      chk($sformatf("tbl%0d_level", i), 48'(level), 48'(tbl[i].lvl));
      chk($sformatf("tbl%0d_in_busy", i), 48'(in_busy), 48'(tbl[i].bsy));
      chk($sformatf("tbl%0d_overflow", i), 48'(overflow), 48'(tbl[i].ovf));
    end
    in_execute = 1'b0; clear_overflow = 1'b0;

    // write at full on the same edge as a dispatch is still dropped
    tpu_busy = 1'b0;
    push(48'hBAD0_BAD0_BAD0, 1'b0);
    chk("full_drop_pulse", 48'(out_execute), 48'h1);
    chk("full_drop_level", 48'(level), 48'h7);
    chk("full_drop_overflow", 48'(overflow), 48'h1);
    chk("full_drop_in_busy", 48'(in_busy), 48'h0);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clear_overflow", 48'(overflow), 48'h0);
    wait_drain("t2_drain", 100);
    chk("t2_level_empty", 48'(level), 48'h0);

    // tpu holds busy 10 cycles after each pulse
    tpu_busy = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push(48'hA5A5_0000_0000 | 48'(i), 1'b1);
    chk("t3_level", 48'(level), 48'h3);
    tpu_busy = 1'b0;
    pulses = 0;
    last = 0;
    for (int n = 0; n < 200 && pulses < 3; n++) begin
      step();
      if (out_execute) begin
        if (pulses > 0) chk("t3_gap", 48'(cyc - last), 48'd12);
        last = cyc;
        pulses++;
        tpu_busy = 1'b1;
        repeat (10) step();
        tpu_busy = 1'b0;
      end
    end
    chk("t3_pulses", 48'(pulses), 48'h3);
    wait_drain("t3_drain", 20);

    // steady level 3 with write and dispatch on the same edge, 20 commands through wrapping pointers
    tpu_busy = 1'b1;
    step();
    for (int i = 0; i < 3; i++) push(48'h5A5A_0000_0000 | 48'(i), 1'b1);
    tpu_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push({16'(i + 16'h100), 32'($urandom)}, 1'b1);
      chk("t4_simul_pulse", 48'(out_execute), 48'h1);
      chk("t4_level_steady", 48'(level), 48'h3);
      repeat (2) step();
    end
    wait_drain("t4_drain", 50);
    chk("t4_level_empty", 48'(level), 48'h0);

    // reset in WAIT with level 5 aborts everything
    tpu_busy = 1'b1;
    step();
    for (int i = 0; i < 6; i++) push(48'h7777_0000_0000 | 48'(i), 1'b1);
    tpu_busy = 1'b0;
    step();
    tpu_busy = 1'b1;
    chk("t6_pre_pulse", 48'(out_execute), 48'h1);
    step();
    chk("t6_pre_level", 48'(level), 48'h5);
    exp_q.delete();
    #2 reset_button = 1'b0;
    #1;
    chk("t6_rst_level", 48'(level), 48'h0);
    chk("t6_rst_out_execute", 48'(out_execute), 48'h0);
    chk("t6_rst_out_command", out_command, 48'h0);
    chk("t6_rst_in_busy", 48'(in_busy), 48'h0);
    chk("t6_rst_overflow", 48'(overflow), 48'h0);
    step();
    reset_button = 1'b1;
    tpu_busy = 1'b0;
    pulses = 0;
    repeat (10) begin
      step();
      if (out_execute) pulses++;
    end
    chk("t6_no_pulse_after_reset", 48'(pulses), 48'h0);
    push(48'h1234_5678_9ABC, 1'b1);
    step();
    chk("t6_new_pulse", 48'(out_execute), 48'h1);
    chk("t6_new_command", out_command, 48'h1234_5678_9ABC);
    wait_drain("t6_drain", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
